// File: rtl/simon_sequencer.sv
// simon_sequencer: game-level sequencer for the Simon Says board.
// Each round adds one random direction to the stored sequence. The whole
// sequence is then played back as timed highlight requests. After that the
// player's clicks are checked one element at a time against the stored sequence.
// All outputs are registered decodes of the current state, so they change
// one cycle after the state does.
module simon_sequencer #(
  parameter int         MAX_LEN    = 16,
  parameter int         ON_CYCLES  = 25_000_000,
  parameter int         OFF_CYCLES = 12_500_000,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         begin_signal,
  input  logic                         clicked,
  input  logic [1:0]                   direction,
  output logic                         show_valid,
  output logic [1:0]                   show_dir,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         game_over,
  output logic                         win
);

  // len counts 0..MAX_LEN, idx addresses 0..MAX_LEN-1.
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = $clog2(MAX_LEN);
  // One shared down-counter serves both the highlight and the dark gap.
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_WAIT_REL,
    ST_FAIL,
    ST_WIN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            clk_q, clk_d;
  logic            beg_q, beg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   len_q, len_d;
  logic [TW-1:0]   timer_q, timer_d;

  // Sequence store. Its contents are don't-care after reset, so it has no reset.
  logic [1:0]      mem_q [MAX_LEN];
  logic            mem_we;
  logic [IW-1:0]   mem_waddr;

  logic            show_valid_q, show_valid_d;
  logic [1:0]      show_dir_q, show_dir_d;
  logic [LW-1:0]   level_q, level_d;
  logic            busy_q, busy_d;
  logic            game_over_q, game_over_d;
  logic            win_q, win_d;

  logic            press;
  logic            start;
  logic            lfsr_fb;
  logic [1:0]      cur_dir;
  logic [LW-1:0]   idx_ext;
  logic [LW-1:0]   last_idx;

  assign press    = clicked & ~clk_q;
  assign start    = begin_signal & ~beg_q;
  // Fibonacci feedback from taps 8,6,5,4, which are bits 7,5,4,3.
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign cur_dir  = mem_q[idx_q];
  assign idx_ext  = LW'(idx_q);
  assign last_idx = len_q - LW'(1);

  // Control state registers. Asynchronous reset puts the game back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      clk_q   <= 1'b0;
      beg_q   <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      clk_q   <= clk_d;
      beg_q   <= beg_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      timer_q <= timer_d;
    end
  end

  // Sequence store write port. Only the ADD state appends an entry.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= lfsr_q[1:0];
    end
  end

  // Next-state logic: LFSR, edge detectors and the game FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    timer_d   = timer_q;
    mem_we    = 1'b0;
    mem_waddr = IW'(len_q);
    // The LFSR and the edge-detect history run in every state.
    lfsr_d    = {lfsr_q[6:0], lfsr_fb};
    clk_d     = clicked;
    beg_d     = begin_signal;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        // len < MAX_LEN here: WAIT_REL goes to WIN instead of ADD at full length.
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        timer_d = ON_LOAD;
        state_d = ST_SHOW_ON;
      end

      ST_SHOW_ON: begin
        if (timer_q == '0) begin
          timer_d = OFF_LOAD;
          state_d = ST_SHOW_OFF;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_SHOW_OFF: begin
        if (timer_q == '0) begin
          if (idx_ext == last_idx) begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + IW'(1);
            timer_d = ON_LOAD;
            state_d = ST_SHOW_ON;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_WAIT_IN: begin
        // Only a rising edge counts. A button held on entry to WAIT_IN is not a press.
        if (press) begin
          if (direction != cur_dir) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_WAIT_REL;
          end
        end
      end

      ST_WAIT_REL: begin
        if (!clicked) begin
          if (idx_ext < last_idx) begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_WAIT_IN;
          end else if (len_q == LEN_MAX) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_ADD;
          end
        end
      end

      ST_FAIL, ST_WIN: begin
        // start takes priority here. A press in the same cycle is not looked at.
        if (start) begin
          len_d   = '0;
          state_d = ST_ADD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the current state, registered below.
  always_comb begin
    show_valid_d = 1'b0;
    show_dir_d   = 2'b00;
    level_d      = len_q;
    busy_d       = 1'b1;
    game_over_d  = 1'b0;
    win_d        = 1'b0;
    case (state_q)
      ST_SHOW_ON: begin
        show_valid_d = 1'b1;
        show_dir_d   = cur_dir;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_FAIL: begin
        busy_d      = 1'b0;
        game_over_d = 1'b1;
      end
      ST_WIN: begin
        busy_d      = 1'b0;
        game_over_d = 1'b1;
        win_d       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers. They clear at the moment reset is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      show_valid_q <= 1'b0;
      show_dir_q   <= 2'b00;
      level_q      <= '0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      show_valid_q <= show_valid_d;
      show_dir_q   <= show_dir_d;
      level_q      <= level_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
    end
  end

  assign show_valid = show_valid_q;
  assign show_dir   = show_dir_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer. It uses MAX_LEN=4, ON=4 and OFF=2.
// A reference LFSR here predicts the direction that each ADD cycle stores.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_simon_sequencer;

  localparam int MAX_LEN    = 4;
  localparam int ON_CYCLES  = 4;
  localparam int OFF_CYCLES = 2;

  logic       clock;
  logic       reset;
  logic       begin_signal;
  logic       clicked;
  logic [1:0] direction;
  logic       show_valid;
  logic [1:0] show_dir;
  logic [2:0] level;
  logic       busy;
  logic       game_over;
  logic       win;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_lfsr;
  logic [1:0] exp_mem [4];
  logic [1:0] cap;

  int         obs_lat;
  int         obs_on  [4];
  int         obs_off [4];
  logic [1:0] obs_dir [4];
  bit         obs_timeout;

  simon_sequencer #(
    .MAX_LEN   (MAX_LEN),
    .ON_CYCLES (ON_CYCLES),
    .OFF_CYCLES(OFF_CYCLES),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .begin_signal(begin_signal),
    .clicked     (clicked),
    .direction   (direction),
    .show_valid  (show_valid),
    .show_dir    (show_dir),
    .level       (level),
    .busy        (busy),
    .game_over   (game_over),
    .win         (win)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference 8-bit Fibonacci LFSR. Taps 8,6,5,4, seed A5, advances every clock.
  always @(posedge clock or posedge reset) begin
    if (reset) model_lfsr <= 8'hA5;
    else       model_lfsr <= {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Start pulse. cap = the LFSR value that the following ADD cycle will store.
  task automatic do_start();
    @(negedge clock);
    begin_signal = 1'b1;
    @(negedge clock);
    cap = model_lfsr[1:0];
    begin_signal = 1'b0;
  endtask

  // One press-hold-release. cap = what a following ADD would store.
  task automatic click(input logic [1:0] d);
    repeat (2) @(negedge clock);
    clicked   = 1'b1;
    direction = d;
    repeat (2) @(negedge clock);
    clicked = 1'b0;
    @(negedge clock);
    cap = model_lfsr[1:0];
  endtask

  // Records the playback of n elements: latency, high/low run lengths, directions.
  task automatic capture(input int n);
    int cnt;
    obs_timeout = 1'b0;
    obs_lat     = 0;
    for (int i = 0; i < 4; i++) begin
      obs_on[i] = 0; obs_off[i] = 0; obs_dir[i] = 2'b00;
    end
    do begin
      @(negedge clock);
      obs_lat++;
    end while (show_valid !== 1'b1 && obs_lat < 64);
    if (show_valid !== 1'b1) begin
      obs_timeout = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      obs_dir[i] = show_dir;
      cnt = 0;
      while (show_valid === 1'b1 && cnt < 64) begin cnt++; @(negedge clock); end
      obs_on[i] = cnt;
      if (i < n - 1) begin
        cnt = 0;
        while (show_valid !== 1'b1 && cnt < 64) begin cnt++; @(negedge clock); end
        obs_off[i] = cnt;
        if (cnt >= 64) begin obs_timeout = 1'b1; return; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; begin_signal = 1'b0; clicked = 1'b0; direction = 2'b00;
    repeat (3) @(negedge clock);
    total++; if (show_valid !== 1'b0) begin bad++; $display("FAIL rst_show_valid got=%0b want=0", show_valid); end
    total++; if (show_dir !== 2'b00) begin bad++; $display("FAIL rst_show_dir got=%0d want=0", show_dir); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over got=%0b want=0", game_over); end
    total++; if (win !== 1'b0) begin bad++; $display("FAIL rst_win got=%0b want=0", win); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", busy); end
    total++; if (show_valid !== 1'b0) begin bad++; $display("FAIL idle_show_valid got=%0b want=0", show_valid); end
    $display("test_reset: done");
  endtask

  task automatic test_first_round();
    do_start();
    exp_mem[0] = cap;
    capture(1);
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL r1_timeout got=%0b want=0", obs_timeout); end
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL r1_latency got=%0d want=2", obs_lat); end
    total++; if (obs_on[0] !== ON_CYCLES) begin bad++; $display("FAIL r1_on_len got=%0d want=%0d", obs_on[0], ON_CYCLES); end
    total++; if (obs_dir[0] !== exp_mem[0]) begin bad++; $display("FAIL r1_dir got=%0d want=%0d", obs_dir[0], exp_mem[0]); end
    total++; if (show_dir !== 2'b00) begin bad++; $display("FAIL r1_dir_dark got=%0d want=0", show_dir); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL r1_level got=%0d want=1", level); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL r1_busy got=%0b want=1", busy); end
    $display("test_first_round: dir0=%0d", exp_mem[0]);
  endtask

  task automatic test_second_round();
    click(exp_mem[0]);
    exp_mem[1] = cap;
    capture(2);
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL r2_timeout got=%0b want=0", obs_timeout); end
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL r2_latency got=%0d want=2", obs_lat); end
    total++; if (obs_on[0] !== ON_CYCLES) begin bad++; $display("FAIL r2_on0 got=%0d want=%0d", obs_on[0], ON_CYCLES); end
    total++; if (obs_off[0] !== OFF_CYCLES) begin bad++; $display("FAIL r2_off0 got=%0d want=%0d", obs_off[0], OFF_CYCLES); end
    total++; if (obs_on[1] !== ON_CYCLES) begin bad++; $display("FAIL r2_on1 got=%0d want=%0d", obs_on[1], ON_CYCLES); end
    for (int i = 0; i < 2; i++) begin
      total++; if (obs_dir[i] !== exp_mem[i]) begin bad++; $display("FAIL r2_dir%0d got=%0d want=%0d", i, obs_dir[i], exp_mem[i]); end
    end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL r2_level got=%0d want=2", level); end
    $display("test_second_round: dir1=%0d", exp_mem[1]);
  endtask

  task automatic test_wrong_press();
    click(exp_mem[0]);
    click(exp_mem[1]);
    exp_mem[2] = cap;
    capture(3);
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL r3_timeout got=%0b want=0", obs_timeout); end
    for (int i = 0; i < 3; i++) begin
      total++; if (obs_dir[i] !== exp_mem[i]) begin bad++; $display("FAIL r3_dir%0d got=%0d want=%0d", i, obs_dir[i], exp_mem[i]); end
    end
    click(exp_mem[0]);
    repeat (2) @(negedge clock);
    clicked   = 1'b1;
    direction = exp_mem[1] ^ 2'b11;
    @(negedge clock);
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL wrong_go_early got=%0b want=0", game_over); end
    @(negedge clock);
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL wrong_game_over got=%0b want=1", game_over); end
    total++; if (win !== 1'b0) begin bad++; $display("FAIL wrong_win got=%0b want=0", win); end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL wrong_level got=%0d want=3", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_busy got=%0b want=0", busy); end
    clicked = 1'b0;
    click(exp_mem[0]);
    click(exp_mem[1]);
    repeat (3) @(negedge clock);
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL hold_game_over got=%0b want=1", game_over); end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL hold_level got=%0d want=3", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%0b want=0", busy); end
    total++; if (show_valid !== 1'b0) begin bad++; $display("FAIL hold_show_valid got=%0b want=0", show_valid); end
    $display("test_wrong_press: done");
  endtask

  task automatic test_start_in_fail();
    @(negedge clock);
    begin_signal = 1'b1;
    clicked      = 1'b1;
    direction    = 2'b00;
    @(negedge clock);
    exp_mem[0]   = model_lfsr[1:0];
    begin_signal = 1'b0;
    clicked      = 1'b0;
    capture(1);
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL sf_timeout got=%0b want=0", obs_timeout); end
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL sf_latency got=%0d want=2", obs_lat); end
    total++; if (obs_dir[0] !== exp_mem[0]) begin bad++; $display("FAIL sf_dir got=%0d want=%0d", obs_dir[0], exp_mem[0]); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL sf_game_over got=%0b want=0", game_over); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL sf_level got=%0d want=1", level); end
    $display("test_start_in_fail: dir0=%0d", exp_mem[0]);
  endtask

  task automatic test_win();
    for (int r = 1; r < MAX_LEN; r++) begin
      for (int i = 0; i < r; i++) click(exp_mem[i]);
      exp_mem[r] = cap;
      capture(r + 1);
      total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL win_r%0d_timeout got=%0b want=0", r + 1, obs_timeout); end
      for (int i = 0; i <= r; i++) begin
        total++; if (obs_dir[i] !== exp_mem[i]) begin bad++; $display("FAIL win_r%0d_dir%0d got=%0d want=%0d", r + 1, i, obs_dir[i], exp_mem[i]); end
      end
      total++; if (level !== 3'(r + 1)) begin bad++; $display("FAIL win_r%0d_level got=%0d want=%0d", r + 1, level, r + 1); end
      $display("test_win: round %0d played", r + 1);
    end
    for (int i = 0; i < MAX_LEN; i++) click(exp_mem[i]);
    @(negedge clock);
    total++; if (win !== 1'b1) begin bad++; $display("FAIL win_flag got=%0b want=1", win); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL win_game_over got=%0b want=1", game_over); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL win_level got=%0d want=4", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL win_busy got=%0b want=0", busy); end
    do_start();
    exp_mem[0] = cap;
    repeat (2) @(negedge clock);
    total++; if (level !== 3'd1) begin bad++; $display("FAIL restart_level got=%0d want=1", level); end
    total++; if (win !== 1'b0) begin bad++; $display("FAIL restart_win got=%0b want=0", win); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_game_over got=%0b want=0", game_over); end
  endtask

  // Playback of round 1 is running. A wrong-direction button goes down now and is held
  // through WAIT_IN entry, and a start pulse arrives while in WAIT_IN.
  task automatic test_gating();
    int n;
    bit reshow;
    bit saw_go;
    reshow = 1'b0;
    saw_go = 1'b0;
    clicked   = 1'b1;
    direction = exp_mem[0] ^ 2'b01;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (k == 9)  begin_signal = 1'b1;
      if (k == 10) begin_signal = 1'b0;
      if (k >= 10 && show_valid === 1'b1) reshow = 1'b1;
      if (game_over === 1'b1) saw_go = 1'b1;
    end
    total++; if (saw_go !== 1'b0) begin bad++; $display("FAIL gate_game_over got=%0b want=0", saw_go); end
    total++; if (reshow !== 1'b0) begin bad++; $display("FAIL gate_start_ignored got=%0b want=0", reshow); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL gate_level got=%0d want=1", level); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gate_busy got=%0b want=1", busy); end
    clicked   = 1'b0;
    direction = 2'b00;
    click(exp_mem[0]);
    exp_mem[1] = cap;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (show_valid !== 1'b1 && n < 20);
    total++; if (n !== 2) begin bad++; $display("FAIL gate_press_latency got=%0d want=2", n); end
    total++; if (show_dir !== exp_mem[0]) begin bad++; $display("FAIL gate_dir got=%0d want=%0d", show_dir, exp_mem[0]); end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL gate_level2 got=%0d want=2", level); end
    $display("test_gating: done");
  endtask

  // Called while round 2 SHOW_ON is highlighting its first element.
  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    total++; if (show_valid !== 1'b0) begin bad++; $display("FAIL mid_show_valid got=%0b want=0", show_valid); end
    total++; if (show_dir !== 2'b00) begin bad++; $display("FAIL mid_show_dir got=%0d want=0", show_dir); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL mid_game_over got=%0b want=0", game_over); end
    total++; if (win !== 1'b0) begin bad++; $display("FAIL mid_win got=%0b want=0", win); end
    @(negedge clock);
    reset = 1'b0;
    do_start();
    exp_mem[0] = cap;
    capture(1);
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL post_rst_timeout got=%0b want=0", obs_timeout); end
    total++; if (obs_dir[0] !== exp_mem[0]) begin bad++; $display("FAIL post_rst_dir0 got=%0d want=%0d", obs_dir[0], exp_mem[0]); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL post_rst_level got=%0d want=1", level); end
    click(exp_mem[0]);
    exp_mem[1] = cap;
    capture(2);
    for (int i = 0; i < 2; i++) begin
      total++; if (obs_dir[i] !== exp_mem[i]) begin bad++; $display("FAIL post_rst_r2_dir%0d got=%0d want=%0d", i, obs_dir[i], exp_mem[i]); end
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_second_round();
    test_wrong_press();
    test_start_in_fail();
    test_win();
    test_gating();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game-level sequencer for the Simon Says board. It builds a random direction sequence one step per round, plays it back as timed highlight requests to the arrow-drawing FSM, and then checks the player's clicks against the stored sequence. It reports the level reached and a win or lose result. It sits between the board input logic (`clicked`, `direction`, `begin_signal`) and the arrow draw/highlight FSM feeding the VGA plotter.

## Interface
- `MAX_LEN`, default 16: sequence length needed to win (2..32).
- `ON_CYCLES`, default 25_000_000: clocks each playback arrow is highlighted (≥1).
- `OFF_CYCLES`, default 12_500_000: dark gap after each highlight (≥1).
- `LFSR_SEED`, default 8'hA5: LFSR reset value (nonzero).
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `begin_signal`, in, 1: start/restart request, level; rising edge acts.
- `clicked`, in, 1: player button, level, synchronized upstream.
- `direction`, in, 2: 00 up, 01 down, 10 right, 11 left; valid while `clicked`=1.
- `show_valid`, out, 1: highlight `show_dir` now.
- `show_dir`, out, 2: direction being played back.
- `level`, out, $clog2(MAX_LEN+1): current sequence length.
- `busy`, out, 1: high in any state except IDLE, FAIL, WIN.
- `game_over`, out, 1: high in FAIL or WIN.
- `win`, out, 1: high in WIN only.

## Operation
- 8-bit Fibonacci LFSR, taps 8,6,5,4. Advances every clock in every state; reset value `LFSR_SEED`.
- Sequence store: MAX_LEN×2-bit register file. Index `idx`, length `len`.
- Edge detect: `clk_q`/`beg_q` registers. `press` = `clicked & ~clk_q`. `start` = `begin_signal & ~beg_q`.
- States and transitions:
  - IDLE: on `start` → ADD with `len`=0.
  - ADD (1 cycle): `mem[len]`←`lfsr[1:0]`, `len`←`len`+1, `idx`←0, timer←ON_CYCLES−1 → SHOW_ON.
  - SHOW_ON: timer decrements. At 0: timer←OFF_CYCLES−1 → SHOW_OFF.
  - SHOW_OFF: at timer 0:
    - if `idx`=`len`−1: `idx`←0 → WAIT_IN;
    - else `idx`++, timer←ON_CYCLES−1 → SHOW_ON.
  - WAIT_IN: on `press`:
    - `direction`≠`mem[idx]` → FAIL;
    - else → WAIT_REL.
  - WAIT_REL: when `clicked`=0:
    - if `idx`<`len`−1: `idx`++ → WAIT_IN;
    - else if `len`=MAX_LEN → WIN;
    - else → ADD.
  - FAIL/WIN: hold. On `start` → ADD with `len`=0.
- Input gating:
  - `clicked` is ignored outside WAIT_IN/WAIT_REL.
  - A button already held on entry to WAIT_IN is not a press; it must be released and pressed again.
  - `start` is ignored in all states except IDLE, FAIL and WIN.
- Outputs:
  - `show_valid`=1 only in SHOW_ON. `show_dir`=`mem[idx]` in SHOW_ON, else 00.
  - `level`=`len` in all states; it holds its final value in FAIL/WIN.

## Timing
- Outputs are registered Moore decodes, valid the cycle after the state is entered.
- Reset values:
  - outputs: `show_valid`=0, `show_dir`=00, `level`=0, `busy`=0, `game_over`=0, `win`=0;
  - internal: state IDLE, `idx`=`len`=0, timer=0, `clk_q`=`beg_q`=0, memory contents don't-care.
- `start` sampled at edge N → ADD during N+1 → SHOW_ON during N+2 → `show_valid` high from N+3.
- Each element: `show_valid` high exactly ON_CYCLES clocks, then low exactly OFF_CYCLES clocks.
- Inter-round gap: final release → ADD → SHOW_ON. `show_valid` rises 3 cycles after `clicked` is sampled low.
- Wrong press: `game_over` rises 2 cycles after the press edge is sampled.
- Reset asserted mid-round (any state): immediate return to all reset values; no partial output.
- `start` coincident with `press` in FAIL: `start` wins, the press is ignored.
- `len` never exceeds MAX_LEN; ADD is unreachable at `len`=MAX_LEN.

## Test plan
Benches use MAX_LEN=4, ON_CYCLES=4, OFF_CYCLES=2, and a bench LFSR model.
- Reset then `begin_signal` pulse → `level`=1, `busy`=1. One `show_valid` burst of 4 cycles; `show_dir` equals the model's `lfsr[1:0]` at the ADD cycle.
- Correct single click (press, release) → ADD. `level`=2; two bursts of 4 high / 2 low cycles, directions matching stored elements 0,1.
- Wrong direction on the second click of round 3 → `game_over`=1, `win`=0, `level`=3, `busy`=0. Further clicks cause no change.
- Four correct rounds → `win`=1, `game_over`=1, `level`=4. A new `begin_signal` edge → `level`=1, `win`=0.
- Clicks during SHOW_ON/SHOW_OFF, and a click held across entry to WAIT_IN, → no state change. The first genuine press after release is evaluated.
- `reset` asserted mid-SHOW_ON in round 2 → all outputs 0 the same cycle. The LFSR returns to 8'hA5.
